// File: rtl/seri_alici.sv
// Serial frame receiver that deserializes one start/data/stop frame into two W-bit operands.
// Optional even-parity bit after the data bits is enabled by defining SERI_ALICI_PARITY_EN.
module seri_alici #(
  parameter int W            = 3,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         rx,
  output logic [W-1:0] operand_a,
  output logic [W-1:0] operand_b,
  output logic         sayi_valid,
  input  logic         sayi_ready,
  output logic         frame_err,
  output logic         overrun
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = $clog2(2*W) + 1;
  localparam logic [CW-1:0] MID      = CW'((CLKS_PER_BIT-1)/2);
  localparam logic [CW-1:0] LAST     = CW'(CLKS_PER_BIT-1);
  localparam logic [BW-1:0] NBITS_M1 = BW'(2*W-1);

`ifdef SERI_ALICI_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
`endif

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [2*W-1:0]   sr_q, sr_d;
  logic [W-1:0]     a_q, a_d, b_q, b_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic             ovr_q, ovr_d;
  logic             good, tick, accept;
`ifdef SERI_ALICI_PARITY_EN
  logic             par_err_q, par_err_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sr_d    = sr_q;
    a_d     = a_q;
    b_d     = b_q;
    valid_d = valid_q;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;
    good    = 1'b0;
`ifdef SERI_ALICI_PARITY_EN
    par_err_d = par_err_q;
`endif
    tick   = (cnt_q == LAST);
    accept = valid_q & sayi_ready;
    if (accept) valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        bit_d = '0;
        if (!rx) begin
          // With a mid-bit index of 0 the detection cycle itself is the confirm sample.
          cnt_d = '0;
          if (MID == '0) state_d = DATA;
          else begin
            state_d = START;
            cnt_d   = CW'(1);
          end
        end
      end
      START: begin
        if (cnt_q == MID) begin
          cnt_d   = '0;
          state_d = rx ? IDLE : DATA;
        end else cnt_d = cnt_q + CW'(1);
      end
      DATA: begin
        if (tick) begin
          cnt_d = '0;
          sr_d  = {rx, sr_q[2*W-1:1]};
          if (bit_q == NBITS_M1) begin
            bit_d = '0;
`ifdef SERI_ALICI_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else bit_d = bit_q + BW'(1);
        end else cnt_d = cnt_q + CW'(1);
      end
`ifdef SERI_ALICI_PARITY_EN
      PARITY: begin
        if (tick) begin
          cnt_d     = '0;
          par_err_d = (^sr_q) ^ rx;
          state_d   = STOP;
        end else cnt_d = cnt_q + CW'(1);
      end
`endif
      STOP: begin
        if (tick) begin
          cnt_d = '0;
          if (!rx) begin
            ferr_d  = 1'b1;
            state_d = BREAK;
          end else begin
            state_d = IDLE;
`ifdef SERI_ALICI_PARITY_EN
            if (par_err_q) ferr_d = 1'b1;
            else           good   = 1'b1;
`else
            good = 1'b1;
`endif
          end
        end else cnt_d = cnt_q + CW'(1);
      end
      BREAK:   if (rx) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // An accept in the same cycle frees the holding register for the new frame.
    if (good) begin
      if (!valid_q || accept) begin
        a_d     = sr_q[W-1:0];
        b_d     = sr_q[2*W-1:W];
        valid_d = 1'b1;
      end else ovr_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sr_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef SERI_ALICI_PARITY_EN
      par_err_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sr_q    <= sr_d;
      a_q     <= a_d;
      b_q     <= b_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
`ifdef SERI_ALICI_PARITY_EN
      par_err_q <= par_err_d;
`endif
    end
  end

  assign operand_a  = a_q;
  assign operand_b  = b_q;
  assign sayi_valid = valid_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;

endmodule
